// File: rtl/calc_control_fsm.sv
// rtl/calc_control_fsm.sv - calculator control FSM and datapath feeding the LED display stage
//
// Collects operand A, an operation and operand B under key control and computes an unsigned
// 2*OPW-bit result. Division is restoring shift-subtract, one quotient bit per clock.
//
// Ports:
//   clk        system clock, only clock domain
//   reset      asynchronous active-high reset (released synchronously inside)
//   power_sw   power switch level, asynchronous
//   key_enter  debounced enter key level, asynchronous
//   key_clear  debounced clear key level, asynchronous
//   sw_val     operand switches, quasi-static
//   sw_op      operation select: 00 add, 01 sub, 10 mul, 11 div
//   state      current FSM state code
//   number     live echo of sw_val, 0 when not powered
//   A/B/C      operand A / operation / operand B captured
//   Error      high only in ERR
//   PowerOn    synchronised power_sw
//   ONE        result, valid in SHOW, 0 elsewhere
module calc_control_fsm #(
  parameter int OPW         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             power_sw,
  input  logic             key_enter,
  input  logic             key_clear,
  input  logic [OPW-1:0]   sw_val,
  input  logic [1:0]       sw_op,
  output logic [3:0]       state,
  output logic [OPW:0]     number,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             Error,
  output logic             PowerOn,
  output logic [2*OPW-1:0] ONE
);

  localparam logic [3:0] S_OFF    = 4'd0;
  localparam logic [3:0] S_GET_A  = 4'd1;
  localparam logic [3:0] S_GET_OP = 4'd2;
  localparam logic [3:0] S_GET_B  = 4'd3;
  localparam logic [3:0] S_CALC   = 4'd4;
  localparam logic [3:0] S_SHOW   = 4'd5;
  localparam logic [3:0] S_ERR    = 4'd6;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam int CNTW = $clog2(OPW + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(OPW - 1);

  // Reset synchroniser: assertion reaches the core immediately, release waits two clocks.
  logic [1:0] rst_pipe_q, rst_pipe_d;
  logic       rst_int;

  always_comb begin
    rst_pipe_d = {rst_pipe_q[0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_pipe_q <= 2'b11;
    else       rst_pipe_q <= rst_pipe_d;
  end

  assign rst_int = rst_pipe_q[1];

  // Input synchronisers and key edge detectors
  logic [SYNC_STAGES-1:0] pwr_sync_q, pwr_sync_d;
  logic [SYNC_STAGES-1:0] ent_sync_q, ent_sync_d;
  logic [SYNC_STAGES-1:0] clr_sync_q, clr_sync_d;
  logic                   ent_prev_q, ent_prev_d;
  logic                   clr_prev_q, clr_prev_d;
  logic                   pwr_s, ent_s, clr_s;
  logic                   ent_edge, clr_edge;

  always_comb begin
    pwr_sync_d = {pwr_sync_q[SYNC_STAGES-2:0], power_sw};
    ent_sync_d = {ent_sync_q[SYNC_STAGES-2:0], key_enter};
    clr_sync_d = {clr_sync_q[SYNC_STAGES-2:0], key_clear};
  end

  assign pwr_s    = pwr_sync_q[SYNC_STAGES-1];
  assign ent_s    = ent_sync_q[SYNC_STAGES-1];
  assign clr_s    = clr_sync_q[SYNC_STAGES-1];
  assign ent_edge = ent_s & ~ent_prev_q;
  assign clr_edge = clr_s & ~clr_prev_q;

  always_comb begin
    ent_prev_d = ent_s;
    clr_prev_d = clr_s;
  end

  // Control and datapath registers
  logic [3:0]       state_q, state_d;
  logic [OPW-1:0]   op_a_q, op_a_d;
  logic [OPW-1:0]   op_b_q, op_b_d;
  logic [1:0]       op_q, op_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             c_q, c_d;
  logic [2*OPW-1:0] result_q, result_d;
  logic [OPW-1:0]   rem_q, rem_d;
  logic [OPW-1:0]   quo_q, quo_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  // Arithmetic results, all zero-extended to 2*OPW
  logic [2*OPW-1:0] add_res, sub_res, mul_res;
  // One restoring-division step: bring the next dividend bit (MSB of quo_q) into the
  // partial remainder and subtract the divisor when it fits.
  logic [OPW:0]     rem_shift;
  logic             div_fits;
  logic [OPW-1:0]   rem_next;
  logic [OPW-1:0]   quo_next;

  always_comb begin
    add_res   = (2*OPW)'(op_a_q) + (2*OPW)'(op_b_q);
    sub_res   = {{OPW{1'b0}}, op_a_q - op_b_q};
    mul_res   = (2*OPW)'(op_a_q) * (2*OPW)'(op_b_q);
    rem_shift = {rem_q, quo_q[OPW-1]};
    div_fits  = rem_shift >= {1'b0, op_b_q};
    // When the divisor fits the difference is below op_b_q, so OPW bits are enough.
    rem_next  = div_fits ? (rem_shift[OPW-1:0] - op_b_q) : rem_shift[OPW-1:0];
    quo_next  = {quo_q[OPW-2:0], div_fits};
  end

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    result_d = result_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;

    if (!pwr_s) begin
      state_d  = S_OFF;
      a_d      = 1'b0;
      b_d      = 1'b0;
      c_d      = 1'b0;
      result_d = '0;
    end else if (state_q > S_ERR) begin
      state_d = S_OFF;
    end else if (clr_edge && state_q != S_OFF) begin
      // Also aborts a division in progress; the divider is reloaded on the next CALC entry.
      state_d  = S_GET_A;
      a_d      = 1'b0;
      b_d      = 1'b0;
      c_d      = 1'b0;
      result_d = '0;
    end else begin
      case (state_q)
        S_OFF: state_d = S_GET_A;
        S_GET_A: begin
          if (ent_edge) begin
            op_a_d  = sw_val;
            a_d     = 1'b1;
            state_d = S_GET_OP;
          end
        end
        S_GET_OP: begin
          if (ent_edge) begin
            op_d    = sw_op;
            b_d     = 1'b1;
            state_d = S_GET_B;
          end
        end
        S_GET_B: begin
          if (ent_edge) begin
            op_b_d  = sw_val;
            c_d     = 1'b1;
            rem_d   = '0;
            quo_d   = op_a_q;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          // Enter edges are deliberately not looked at here.
          case (op_q)
            OP_ADD: begin
              result_d = add_res;
              state_d  = S_SHOW;
            end
            OP_SUB: begin
              if (op_a_q < op_b_q) begin
                state_d = S_ERR;
              end else begin
                result_d = sub_res;
                state_d  = S_SHOW;
              end
            end
            OP_MUL: begin
              result_d = mul_res;
              state_d  = S_SHOW;
            end
            default: begin
              if (op_b_q == '0) begin
                state_d = S_ERR;
              end else begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                  result_d = (2*OPW)'(quo_next);
                  state_d  = S_SHOW;
                end
              end
            end
          endcase
        end
        S_SHOW, S_ERR: begin
          if (ent_edge) begin
            state_d  = S_GET_A;
            a_d      = 1'b0;
            b_d      = 1'b0;
            c_d      = 1'b0;
            result_d = '0;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      pwr_sync_q <= '0;
      ent_sync_q <= '0;
      clr_sync_q <= '0;
      ent_prev_q <= 1'b0;
      clr_prev_q <= 1'b0;
      state_q    <= S_OFF;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_q       <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      c_q        <= 1'b0;
      result_q   <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
    end else begin
      pwr_sync_q <= pwr_sync_d;
      ent_sync_q <= ent_sync_d;
      clr_sync_q <= clr_sync_d;
      ent_prev_q <= ent_prev_d;
      clr_prev_q <= clr_prev_d;
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      result_q   <= result_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
    end
  end

  assign state   = state_q;
  assign number  = pwr_s ? {1'b0, sw_val} : '0;
  assign A       = a_q;
  assign B       = b_q;
  assign C       = c_q;
  assign Error   = (state_q == S_ERR);
  assign PowerOn = pwr_s;
  assign ONE     = (state_q == S_SHOW) ? result_q : '0;

endmodule

// File: tb/tb_calc_control_fsm.sv
// tb/tb_calc_control_fsm.sv - self-checking bench for calc_control_fsm
module tb_calc_control_fsm;

  localparam int ST_OFF = 0, ST_GET_A = 1, ST_GET_OP = 2, ST_GET_B = 3;
  localparam int ST_CALC = 4, ST_SHOW = 5, ST_ERR = 6;

  logic       clk = 1'b0;
  logic       reset, power_sw, key_enter, key_clear;
  logic [3:0] sw_val;
  logic [1:0] sw_op;
  logic [3:0] state;
  logic [4:0] number;
  logic       A, B, C, Error, PowerOn;
  logic [7:0] ONE;

  int checks = 0;
  int errors = 0;

  calc_control_fsm dut (
    .clk(clk), .reset(reset), .power_sw(power_sw), .key_enter(key_enter),
    .key_clear(key_clear), .sw_val(sw_val), .sw_op(sw_op), .state(state),
    .number(number), .A(A), .B(B), .C(C), .Error(Error), .PowerOn(PowerOn), .ONE(ONE)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  typedef struct {
    int a; int op; int b; int st; int one; int cyc; bit exit_clr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Holds the keys for three clocks, so the action lands on the last of them.
  task automatic press(input bit ent, input bit clr);
    key_enter = ent;
    key_clear = clr;
    tick(3);
    key_enter = 1'b0;
    key_clear = 1'b0;
  endtask

  function automatic void model(input int a, input int op, input int b,
                                output int st, output int one, output int cyc);
    st = ST_SHOW; one = 0; cyc = 1;
    case (op)
      0: one = a + b;
      1: if (a < b) st = ST_ERR; else one = a - b;
      2: one = a * b;
      default: if (b == 0) st = ST_ERR; else begin one = a / b; cyc = 4; end
    endcase
  endfunction

  task automatic run_calc(input string tag, input vec_t v);
    int n;
    sw_val = 4'(v.a);
    #1;
    chk({tag, " number echo"}, number, v.a);
    press(1'b1, 1'b0);
    chk({tag, " state GET_OP"}, state, ST_GET_OP);
    chk({tag, " A set"}, A, 1);
    tick(3);
    sw_op = 2'(v.op);
    press(1'b1, 1'b0);
    chk({tag, " state GET_B"}, state, ST_GET_B);
    chk({tag, " B set"}, B, 1);
    tick(3);
    sw_val = 4'(v.b);
    press(1'b1, 1'b0);
    n = 0;
    while (state == 4'(ST_CALC) && n < 20) begin
      n++;
      tick(1);
    end
    chk({tag, " CALC cycles"}, n, v.cyc);
    chk({tag, " final state"}, state, v.st);
    chk({tag, " ONE"}, ONE, v.one);
    chk({tag, " Error"}, Error, (v.st == ST_ERR) ? 1 : 0);
    chk({tag, " ABC"}, {A, B, C}, 7);
    tick(3);
    chk({tag, " ONE hold"}, ONE, v.one);
    press(!v.exit_clr, v.exit_clr);
    chk({tag, " back GET_A"}, state, ST_GET_A);
    chk({tag, " ABC clear"}, {A, B, C}, 0);
    chk({tag, " ONE clear"}, ONE, 0);
    chk({tag, " Error clear"}, Error, 0);
    tick(3);
  endtask

  task automatic enter_ab(input int a, input int op, input int b);
    sw_val = 4'(a);
    press(1'b1, 1'b0);
    tick(3);
    sw_op = 2'(op);
    press(1'b1, 1'b0);
    tick(3);
    sw_val = 4'(b);
  endtask

  vec_t vecs[10];

  initial begin
    vec_t rv;
    vecs[0] = '{7, 2, 9, ST_SHOW, 63, 1, 1'b0};
    vecs[1] = '{13, 3, 4, ST_SHOW, 3, 4, 1'b0};
    vecs[2] = '{13, 3, 0, ST_ERR, 0, 1, 1'b0};
    vecs[3] = '{3, 1, 5, ST_ERR, 0, 1, 1'b0};
    vecs[4] = '{9, 1, 4, ST_SHOW, 5, 1, 1'b1};
    vecs[5] = '{15, 2, 15, ST_SHOW, 225, 1, 1'b0};
    vecs[6] = '{15, 0, 15, ST_SHOW, 30, 1, 1'b1};
    vecs[7] = '{0, 3, 1, ST_SHOW, 0, 4, 1'b0};
    vecs[8] = '{15, 3, 1, ST_SHOW, 15, 4, 1'b1};
    vecs[9] = '{5, 1, 5, ST_SHOW, 0, 1, 1'b1};

    reset = 1'b1; power_sw = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
    sw_val = 4'd5; sw_op = 2'b00;
    tick(3);
    chk("reset state", state, ST_OFF);
    chk("reset ONE", ONE, 0);
    chk("reset ABC", {A, B, C}, 0);
    chk("reset Error", Error, 0);
    chk("reset PowerOn", PowerOn, 0);
    chk("reset number", number, 0);
    reset = 1'b0;
    tick(4);
    chk("unpowered stays OFF", state, ST_OFF);

    power_sw = 1'b1;
    tick(1);
    chk("power clk1 state", state, ST_OFF);
    tick(1);
    chk("power clk2 PowerOn", PowerOn, 1);
    tick(1);
    chk("power clk3 GET_A", state, ST_GET_A);
    chk("power ONE", ONE, 0);
    chk("power ABC", {A, B, C}, 0);
    tick(2);

    for (int i = 0; i < 10; i++) run_calc($sformatf("vec%0d", i), vecs[i]);

    for (int i = 0; i < 24; i++) begin
      rv.a  = int'($urandom_range(0, 15));
      rv.op = int'($urandom_range(0, 3));
      rv.b  = int'($urandom_range(0, 15));
      rv.exit_clr = 1'($urandom_range(0, 1));
      model(rv.a, rv.op, rv.b, rv.st, rv.one, rv.cyc);
      run_calc($sformatf("rnd%0d %0d op%0d %0d", i, rv.a, rv.op, rv.b), rv);
    end

    // Clear and enter rising together in GET_B: clear wins.
    enter_ab(6, 0, 2);
    press(1'b1, 1'b1);
    chk("clr+ent state", state, ST_GET_A);
    chk("clr+ent ABC", {A, B, C}, 0);
    tick(3);

    // Clear arriving during the third division cycle aborts it.
    enter_ab(13, 3, 4);
    press(1'b1, 1'b0);
    chk("middiv in CALC", state, ST_CALC);
    press(1'b0, 1'b1);
    chk("middiv clear state", state, ST_GET_A);
    chk("middiv clear ONE", ONE, 0);
    chk("middiv clear ABC", {A, B, C}, 0);
    tick(3);

    // Power drop during SHOW.
    enter_ab(7, 2, 9);
    press(1'b1, 1'b0);
    tick(1);
    chk("pwr show ONE", ONE, 63);
    power_sw = 1'b0;
    tick(2);
    chk("pwr drop PowerOn", PowerOn, 0);
    tick(1);
    chk("pwr drop state", state, ST_OFF);
    chk("pwr drop ONE", ONE, 0);
    chk("pwr drop ABC", {A, B, C}, 0);
    chk("pwr drop Error", Error, 0);
    chk("pwr drop number", number, 0);
    power_sw = 1'b1;
    tick(3);
    chk("repower GET_A", state, ST_GET_A);
    tick(2);

    // Reset asserted mid-CALC takes effect without a clock edge.
    enter_ab(13, 3, 4);
    press(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("rst midcalc state", state, ST_OFF);
    chk("rst midcalc C", C, 0);
    chk("rst midcalc PowerOn", PowerOn, 0);
    @(negedge clk);
    reset = 1'b0;
    tick(6);
    chk("post reset GET_A", state, ST_GET_A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
